// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls a branch in IF/ID until its
// operands are forwardable, flushes IF/ID when it resolves taken.
module branch_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             IFID_branch,
   input  logic [4:0]       IFID_rs,
   input  logic [4:0]       IFID_rt,
   input  logic             branchTaken,
   input  logic [4:0]       IDEX_rd,
   input  logic             IDEX_regWrite,
   input  logic             IDEX_memRead,
   input  logic [4:0]       EXMEM_rd,
   input  logic             EXMEM_regWrite,
   input  logic             EXMEM_memRead,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEX_bubble,
   output logic             IFID_flush,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      STALL_LD = 1'b1
   } state_t;

   state_t state, stateNext;

   logic matchEX, matchMEM;
   logic ldEX, aluEX, ldMEM;
   logic stall, flush;

   assign matchEX = (IDEX_rd != 5'd0) &&
                    ((IDEX_rd == IFID_rs) || (IDEX_rd == IFID_rt));
   assign matchMEM = (EXMEM_rd != 5'd0) &&
                     ((EXMEM_rd == IFID_rs) || (EXMEM_rd == IFID_rt));

   assign ldEX  = matchEX & IDEX_regWrite & IDEX_memRead;
   assign aluEX = matchEX & IDEX_regWrite & ~IDEX_memRead;
   assign ldMEM = matchMEM & EXMEM_regWrite & EXMEM_memRead;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Reset forces the outputs inactive even though state is already IDLE
   always_comb begin
      stateNext = state;
      stall     = 1'b0;
      flush     = 1'b0;
      if (!Reset) begin
         case (state)
            IDLE: begin
               if (IFID_branch) begin
                  if (ldEX) begin
                     stall     = 1'b1;
                     stateNext = STALL_LD;
                  end else if (aluEX || ldMEM) begin
                     stall = 1'b1;
                  end else begin
                     flush = branchTaken;
                  end
               end
            end
            STALL_LD: begin
               stall     = 1'b1;
               stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   assign PCWrite     = ~stall;
   assign IFIDWrite   = ~stall;
   assign IDEX_bubble = stall;
   assign IFID_flush  = flush;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (stall && (stallCount != '1)) stallCount <= stallCount + 1'b1;
         if (flush && (flushCount != '1)) flushCount <= flushCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_branch_hazard_ctrl;

   localparam int CW  = 5;
   localparam int MAX = (1 << CW) - 1;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          IFID_branch;
   logic [4:0]    IFID_rs, IFID_rt;
   logic          branchTaken;
   logic [4:0]    IDEX_rd;
   logic          IDEX_regWrite, IDEX_memRead;
   logic [4:0]    EXMEM_rd;
   logic          EXMEM_regWrite, EXMEM_memRead;
   logic          PCWrite, IFIDWrite, IDEX_bubble, IFID_flush;
   logic [CW-1:0] stallCount, flushCount;

   int total = 0;
   int bad   = 0;
   bit checking = 0;

   // model: stalls still owed after the current cycle, plus counters
   int pend = 0;
   int mStall = 0;
   int mFlush = 0;

   branch_hazard_ctrl #(.CNT_W(CW)) dut (
      .Clock(Clock), .Reset(Reset),
      .IFID_branch(IFID_branch), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
      .branchTaken(branchTaken),
      .IDEX_rd(IDEX_rd), .IDEX_regWrite(IDEX_regWrite),
      .IDEX_memRead(IDEX_memRead),
      .EXMEM_rd(EXMEM_rd), .EXMEM_regWrite(EXMEM_regWrite),
      .EXMEM_memRead(EXMEM_memRead),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush),
      .stallCount(stallCount), .flushCount(flushCount)
   );

   always #5 Clock = ~Clock;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit hitEx();
      return IDEX_rd != 0 && (IDEX_rd == IFID_rs || IDEX_rd == IFID_rt)
             && IDEX_regWrite;
   endfunction

   function automatic bit hitMemLoad();
      return EXMEM_rd != 0 && (EXMEM_rd == IFID_rs || EXMEM_rd == IFID_rt)
             && EXMEM_regWrite && EXMEM_memRead;
   endfunction

   // expected {stall, flush} for the current cycle
   function automatic logic [1:0] expect2();
      if (Reset) return 2'b00;
      if (pend > 0) return 2'b10;
      if (!IFID_branch) return 2'b00;
      if (hitEx() || hitMemLoad()) return 2'b10;
      return {1'b0, branchTaken};
   endfunction

   always @(posedge Clock or posedge Reset) begin
      logic [1:0] e;
      if (Reset) begin
         pend = 0; mStall = 0; mFlush = 0;
      end else begin
         e = expect2();
         if (e[1] && mStall < MAX) mStall++;
         if (e[0] && mFlush < MAX) mFlush++;
         if (pend > 0) pend--;
         else if (IFID_branch && hitEx() && IDEX_memRead) pend = 1;
      end
   end

   always @(negedge Clock) begin
      logic [1:0] e;
      if (checking) begin
         e = expect2();
         chk("cmp_out", {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush},
             e[1] ? 4'b0010 : {2'b11, 1'b0, e[0]});
         chk("cmp_cnt", {stallCount, flushCount},
             {mStall[CW-1:0], mFlush[CW-1:0]});
      end
   end

   task automatic clr();
      IFID_branch = 0; IFID_rs = 0; IFID_rt = 0; branchTaken = 0;
      IDEX_rd = 0; IDEX_regWrite = 0; IDEX_memRead = 0;
      EXMEM_rd = 0; EXMEM_regWrite = 0; EXMEM_memRead = 0;
   endtask

   task automatic step();
      @(posedge Clock); #1;
   endtask

   task automatic mid();
      @(negedge Clock);
   endtask

   task automatic rst();
      Reset = 1; step(); Reset = 0;
   endtask

   initial begin
      clr();
      Reset = 1;
      IFID_branch = 1; IFID_rs = 1; IDEX_rd = 1;
      IDEX_regWrite = 1; IDEX_memRead = 1;
      step();
      mid();
      chk("reset_out", {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush}, 4'b1100);
      chk("reset_cnt", {stallCount, flushCount}, 0);
      checking = 1;
      step();

      // load in EX, then in MEM: two stalls then resolve
      rst(); clr();
      IFID_branch = 1; IFID_rs = 1;
      IDEX_rd = 1; IDEX_regWrite = 1; IDEX_memRead = 1;
      mid(); chk("ld_c1_pc", PCWrite, 0);
      step();
      IDEX_rd = 0; IDEX_regWrite = 0; IDEX_memRead = 0;
      EXMEM_rd = 1; EXMEM_regWrite = 1; EXMEM_memRead = 1;
      mid(); chk("ld_c2_bub", IDEX_bubble, 1);
      step();
      EXMEM_rd = 0; EXMEM_regWrite = 0; EXMEM_memRead = 0;
      mid(); chk("ld_c3_pc", PCWrite, 1);
      chk("ld_cnt", stallCount, 2);
      step();

      // ALU producer in EX, taken branch
      rst(); clr();
      IFID_branch = 1; IFID_rt = 3; branchTaken = 1;
      IDEX_rd = 3; IDEX_regWrite = 1;
      mid(); chk("alu_c1", {PCWrite, IFID_flush}, 2'b00);
      step();
      IDEX_rd = 0; IDEX_regWrite = 0;
      EXMEM_rd = 3; EXMEM_regWrite = 1;
      mid(); chk("alu_c2", {PCWrite, IFID_flush}, 2'b11);
      step(); clr();
      mid(); chk("alu_cnt", {stallCount, flushCount}, {5'd1, 5'd1});
      step();

      // register 0 never matches
      clr();
      IFID_branch = 1; IDEX_regWrite = 1; IDEX_memRead = 1;
      mid(); chk("r0", {PCWrite, IDEX_bubble, IFID_flush}, 3'b100);
      step();

      // ldEX and ldMEM together: two stalls, no flush
      rst(); clr();
      IFID_branch = 1; branchTaken = 1;
      IFID_rs = 1; IDEX_rd = 1; IDEX_regWrite = 1; IDEX_memRead = 1;
      IFID_rt = 2; EXMEM_rd = 2; EXMEM_regWrite = 1; EXMEM_memRead = 1;
      mid(); chk("pri_c1", {PCWrite, IFID_flush}, 2'b00);
      step();
      mid(); chk("pri_c2", {PCWrite, IFID_flush}, 2'b00);
      step();
      clr(); IFID_branch = 1; branchTaken = 1;
      mid(); chk("pri_c3", IFID_flush, 1);
      chk("pri_cnt", stallCount, 2);
      step();

      // branch drops while in second load stall
      clr();
      IFID_branch = 1; IFID_rs = 6;
      IDEX_rd = 6; IDEX_regWrite = 1; IDEX_memRead = 1;
      step();
      clr();
      mid(); chk("drop_c2", PCWrite, 0);
      step();

      // reset in the middle of a load stall abandons it
      IFID_branch = 1; IFID_rs = 6;
      IDEX_rd = 6; IDEX_regWrite = 1; IDEX_memRead = 1;
      step();
      clr(); IFID_branch = 1;
      chk("mid_ld", PCWrite, 0);
      #1 Reset = 1;
      #1 Reset = 0;
      #1 chk("mid_rst", PCWrite, 1);
      step();

      // saturate the stall counter, then async reset
      rst(); clr();
      IFID_branch = 1; IFID_rs = 4; IDEX_rd = 4; IDEX_regWrite = 1;
      repeat ((1 << CW) + 5) step();
      mid(); chk("sat", stallCount, MAX);
      @(posedge Clock); #2;
      Reset = 1;
      #1 chk("async_cnt", stallCount, 0);
      chk("async_out", PCWrite, 1);
      #1 Reset = 0;
      step();

      // randomized traffic against the model
      clr();
      repeat (3000) begin
         step();
         Reset          = ($urandom_range(0, 80) == 0);
         IFID_branch    = ($urandom_range(0, 3) != 0);
         IFID_rs        = 5'($urandom_range(0, 3));
         IFID_rt        = 5'($urandom_range(0, 3));
         branchTaken    = 1'($urandom);
         IDEX_rd        = 5'($urandom_range(0, 3));
         IDEX_regWrite  = 1'($urandom);
         IDEX_memRead   = 1'($urandom);
         EXMEM_rd       = 5'($urandom_range(0, 3));
         EXMEM_regWrite = 1'($urandom);
         EXMEM_memRead  = 1'($urandom);
      end
      step();
      checking = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Stall/flush sequencer for the ID-stage branch resolution path of the 5-stage MIPS pipeline. It decides, each cycle, whether a branch sitting in IF/ID can be resolved now, using the values the Branch forwarding unit can supply. If it cannot, the block freezes PC and IF/ID and injects bubbles into ID/EX until the operands are forwardable. Once the branch resolves taken, it flushes IF/ID. It also keeps saturating stall and flush counters for performance reporting.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- Clock  in  1  pipeline clock, rising-edge
- Reset  in  1  asynchronous, active-high reset
- IFID_branch  in  1  instruction in IF/ID is a conditional branch (beq/bne)
- IFID_rs  in  5  branch source register A
- IFID_rt  in  5  branch source register B
- branchTaken  in  1  ID comparator result, using forwarded operands
- IDEX_rd  in  5  destination register of the instruction in EX
- IDEX_regWrite  in  1  EX instruction writes a register
- IDEX_memRead  in  1  EX instruction is a load
- EXMEM_rd  in  5  destination register of the instruction in MEM
- EXMEM_regWrite  in  1  MEM instruction writes a register
- EXMEM_memRead  in  1  MEM instruction is a load
- PCWrite  out  1  0 = hold PC
- IFIDWrite  out  1  0 = hold IF/ID
- IDEX_bubble  out  1  1 = zero ID/EX control (insert nop)
- IFID_flush  out  1  1 = clear IF/ID on next edge
- stallCount  out  CNT_W  saturating count of stall cycles
- flushCount  out  CNT_W  saturating count of taken-branch flushes

## Operation
Match rules (register 0 never matches):
- matchEX = IDEX_rd != 0 and (IDEX_rd == IFID_rs or IDEX_rd == IFID_rt)
- matchMEM = EXMEM_rd != 0 and (EXMEM_rd == IFID_rs or EXMEM_rd == IFID_rt)

Hazard classes, evaluated only in IDLE with IFID_branch=1:
- ldEX = matchEX & IDEX_regWrite & IDEX_memRead. Needs 2 stall cycles.
- aluEX = matchEX & IDEX_regWrite & !IDEX_memRead. Needs 1 stall cycle.
- ldMEM = matchMEM & EXMEM_regWrite & EXMEM_memRead. Needs 1 stall cycle.

States (2, encoded): IDLE, STALL_LD.
- IDLE, ldEX: stall this cycle, next = STALL_LD.
- IDLE, aluEX or ldMEM (without ldEX): stall this cycle, next = IDLE. Re-evaluate next cycle.
- IDLE, IFID_branch and no hazard: resolve this cycle. IFID_flush = branchTaken. Next = IDLE.
- IDLE, IFID_branch=0: all outputs inactive.
- STALL_LD: stall unconditionally, regardless of inputs. Next = IDLE, where the branch is re-evaluated (normally now no hazard).

Output rules:
- Stall means PCWrite=0, IFIDWrite=0, IDEX_bubble=1, IFID_flush=0.
- Inactive means PCWrite=1, IFIDWrite=1, IDEX_bubble=0, IFID_flush=0.
- Stall and flush are never asserted together. Stall has priority; branchTaken is ignored during any stall cycle.

Counters:
- stallCount increments by 1 on each clock edge ending a stall cycle.
- flushCount increments by 1 on each edge where IFID_flush=1.
- Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- PCWrite, IFIDWrite, IDEX_bubble and IFID_flush are combinational (Mealy) from the state and current inputs, valid in the same cycle the hazard is presented.
- State and counters are registered on the rising Clock edge.
- Load in EX feeding a branch: exactly 2 stall cycles, then resolve in the 3rd cycle.
- ALU op in EX feeding a branch: 1 stall cycle, then resolve.
- Load in MEM feeding a branch: 1 stall cycle, then resolve.
- No hazard: 0 stall cycles; the branch resolves in the cycle it is presented.
- Reset asserted:
  - State goes to IDLE immediately and both counters clear to 0, without waiting for a clock edge.
  - While Reset=1, outputs are forced inactive irrespective of inputs.
- Reset mid-STALL_LD: the stall is abandoned; after release the block re-evaluates from IDLE.
- Simultaneous ldEX and ldMEM (rs and rt hit different loads): ldEX wins, giving a 2-cycle stall.
- IFID_branch dropping while in STALL_LD: the second stall cycle is still issued.

## Test plan
- Reset: Reset=1 with IFID_branch=1 and ldEX conditions present -> PCWrite=1, IFIDWrite=1, IDEX_bubble=0, IFID_flush=0, stallCount=0, flushCount=0.
- Load-use: IFID_rs=1, IDEX_rd=1, IDEX_regWrite=1, IDEX_memRead=1. Next cycle move the load to EXMEM (EXMEM_rd=1, EXMEM_memRead=1, IDEX_* cleared) -> PCWrite=0 for exactly 2 cycles, then resolve; stallCount=2.
- ALU dependency: IFID_rt=3, IDEX_rd=3, IDEX_regWrite=1, IDEX_memRead=0, branchTaken=1. Next cycle the producer moves to EXMEM (EXMEM_rd=3, EXMEM_regWrite=1, EXMEM_memRead=0) -> 1 stall cycle, then IFID_flush=1 for 1 cycle; stallCount=1, flushCount=1.
- Register 0: IFID_rs=0, IDEX_rd=0, IDEX_regWrite=1, IDEX_memRead=1, branchTaken=0 -> no stall, IFID_flush=0.
- Priority: IFID_rs=1, IDEX_rd=1 (load in EX), IFID_rt=2, EXMEM_rd=2 (load in MEM), branchTaken=1 -> 2 stall cycles, IFID_flush=0 throughout both.
- Saturation and async reset: run 2^CNT_W+5 stall cycles -> stallCount holds at all ones. Then assert Reset between clock edges -> stallCount=0 and state=IDLE immediately.
